// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared states and constants for the SCCB boot configuration master
package sccb_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_FETCH, SEQ_DECODE, SEQ_WRITE, SEQ_DELAY, SEQ_NEXT, SEQ_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    PHY_IDLE, PHY_START, PHY_BYTE, PHY_STOP, PHY_GAP
  } phy_state_e;

  localparam logic [15:0] SENTINEL_END   = 16'hFFFF;
  localparam logic [15:0] SENTINEL_DELAY = 16'hFFF0;
  localparam int          BITS_PER_PHASE = 9;
  localparam int          PHASES         = 3;

endpackage

// File: rtl/sccb_write_phy.sv
// rtl/sccb_write_phy.sv - one SCCB 3-phase write: START, 27 bits, STOP, bus-free gap
module sccb_write_phy
  import sccb_pkg::*;
#(
  parameter int QTR = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] id,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       ack,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_t,
  input  logic       siod_i,
  output logic [7:0] nack_cnt
);

  localparam int QW = $clog2(QTR);

  phy_state_e    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    q_q, q_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    id_q, id_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]    nack_q, nack_d;
  logic          sioc_q, sioc_d, siod_o_q, siod_o_d, siod_t_q, siod_t_d;
  logic          tick, unit_end, dc_bit;
  logic [7:0]    cur_byte;

  assign tick     = (qcnt_q == QW'(QTR - 1));
  assign unit_end = tick && (q_q == 2'd3);
  assign dc_bit   = (bit_q == 4'(BITS_PER_PHASE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PHY_IDLE;
      qcnt_q   <= '0;
      q_q      <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      nack_q   <= '0;
      sioc_q   <= 1'b1;
      siod_o_q <= 1'b0;
      siod_t_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      q_q      <= q_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      nack_q   <= nack_d;
      sioc_q   <= sioc_d;
      siod_o_q <= siod_o_d;
      siod_t_q <= siod_t_d;
    end
  end

  // Outputs are computed per quarter and registered, so SIOC and SIOD move on the same edge.
  always_comb begin
    state_d  = state_q;
    qcnt_d   = tick ? '0 : qcnt_q + QW'(1);
    q_d      = tick ? q_q + 2'd1 : q_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    id_d     = id_q;
    addr_d   = addr_q;
    data_d   = data_q;
    nack_d   = nack_q;
    ack      = 1'b0;
    sioc_d   = 1'b1;
    siod_o_d = 1'b0;
    siod_t_d = 1'b1;
    cur_byte = data_q;
    if (phase_q == 2'd0) cur_byte = id_q;
    else if (phase_q == 2'd1) cur_byte = addr_q;

    case (state_q)
      PHY_IDLE: begin
        qcnt_d = '0;
        q_d    = '0;
        if (go) begin
          state_d = PHY_START;
          id_d    = id;
          addr_d  = addr;
          data_d  = data;
        end
      end
      PHY_START: begin
        sioc_d   = (q_q != 2'd3);
        siod_t_d = (q_q == 2'd0);
        if (unit_end) begin
          state_d = PHY_BYTE;
          bit_d   = '0;
          phase_d = '0;
        end
      end
      PHY_BYTE: begin
        sioc_d = q_q[0] ^ q_q[1];
        if (!dc_bit) begin
          siod_t_d = 1'b0;
          siod_o_d = cur_byte[~bit_q[2:0]];
        end
        if (dc_bit && q_q == 2'd2 && qcnt_q == '0 && siod_i && nack_q != 8'hFF)
          nack_d = nack_q + 8'd1;
        if (unit_end) begin
          if (dc_bit) begin
            bit_d = '0;
            if (phase_q == 2'(PHASES - 1)) state_d = PHY_STOP;
            else phase_d = phase_q + 2'd1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PHY_STOP: begin
        sioc_d   = (q_q != 2'd0);
        siod_t_d = q_q[1];
        if (unit_end) state_d = PHY_GAP;
      end
      PHY_GAP: begin
        if (unit_end) begin
          state_d = PHY_IDLE;
          ack     = 1'b1;
        end
      end
      default: state_d = PHY_IDLE;
    endcase
  end

  assign sioc     = sioc_q;
  assign siod_o   = siod_o_q;
  assign siod_t   = siod_t_q;
  assign nack_cnt = nack_q;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// rtl/sccb_cfg_sequencer.sv - walks the ROM register table and hands each entry to the write PHY
module sccb_cfg_sequencer
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ     = 100_000_000,
  parameter int         SCCB_FREQ    = 100_000,
  parameter logic [7:0] SLAVE_ADDR   = 8'h42,
  parameter int         ROM_AW       = 8,
  parameter int         DELAY_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_o,
  output logic              siod_t,
  input  logic              siod_i,
  output logic [7:0]        nack_cnt
);

  localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int CW  = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;

  seq_state_e        state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              go, ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // cnt_q serves both the ROM latency wait and the delay sentinel.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q + CW'(1);
    busy_d  = busy_q;
    done_d  = done_q;
    go      = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SEQ_FETCH;
          addr_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      SEQ_FETCH: begin
        if (cnt_q == CW'(1)) state_d = SEQ_DECODE;
      end
      SEQ_DECODE: begin
        cnt_d = '0;
        if (rom_data == SENTINEL_END) begin
          state_d = SEQ_DONE;
        end else if (rom_data == SENTINEL_DELAY) begin
          state_d = SEQ_DELAY;
        end else begin
          go      = 1'b1;
          state_d = SEQ_WRITE;
        end
      end
      SEQ_WRITE: begin
        cnt_d = '0;
        if (ack) state_d = SEQ_NEXT;
      end
      SEQ_DELAY: begin
        if (cnt_q == CW'(DELAY_CYCLES - 1)) state_d = SEQ_NEXT;
      end
      SEQ_NEXT: begin
        cnt_d = '0;
        if (addr_q == '1) begin
          state_d = SEQ_DONE;
        end else begin
          addr_d  = addr_q + ROM_AW'(1);
          state_d = SEQ_FETCH;
        end
      end
      SEQ_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  sccb_write_phy #(.QTR(QTR)) u_phy (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .id       (SLAVE_ADDR),
    .addr     (rom_data[15:8]),
    .data     (rom_data[7:0]),
    .ack      (ack),
    .sioc     (sioc),
    .siod_o   (siod_o),
    .siod_t   (siod_t),
    .siod_i   (siod_i),
    .nack_cnt (nack_cnt)
  );

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// tb/tb_sccb_cfg_sequencer.sv - directed bench for the SCCB configuration sequencer
module tb_sccb_cfg_sequencer;

  localparam logic [26:0] TPAT = 27'b000000001_000000001_000000001;

  logic        clk;
  logic        rst_n, start, busy, done, sioc, siod_o, siod_t, siod_i;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  nack_cnt;
  logic [15:0] rom [4];
  logic        pull_high;

  logic        s_rst_n, s_start, s_busy, s_done, s_sioc, s_siod_o, s_siod_t, s_siod_i;
  logic [1:0]  s_rom_addr;
  logic [15:0] s_rom_data;
  logic [7:0]  s_nack;
  logic        sat_fin;

  int checks = 0, failures = 0;
  int tcnt = 0, t0 = 0, t_start = 0, first_start = 0, last_span = 0;
  int nbits = 0, bad_frames = 0, early_low = 0;
  logic in_frame = 1'b0, p_sioc = 1'b1, p_line = 1'b1, line;
  logic [27:0] sr, tsr;
  logic [26:0] frames[$], tpats[$];

  sccb_cfg_sequencer #(.CLK_FREQ(400), .SCCB_FREQ(10), .SLAVE_ADDR(8'h42),
                       .ROM_AW(2), .DELAY_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .sioc(sioc), .siod_o(siod_o),
    .siod_t(siod_t), .siod_i(siod_i), .nack_cnt(nack_cnt));

  sccb_cfg_sequencer #(.CLK_FREQ(8), .SCCB_FREQ(1), .SLAVE_ADDR(8'h42),
                       .ROM_AW(2), .DELAY_CYCLES(50)) dut_sat (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data), .sioc(s_sioc), .siod_o(s_siod_o),
    .siod_t(s_siod_t), .siod_i(s_siod_i), .nack_cnt(s_nack));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign line     = siod_t | siod_o;
  assign siod_i   = pull_high ? line : (siod_t ? 1'b0 : siod_o);
  assign s_siod_i = s_siod_t | s_siod_o;

  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) s_rom_data <= 16'h0102 + {14'd0, s_rom_addr};

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {a, 1'b1, b, 1'b1, c, 1'b1};
  endfunction

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    frames.delete();
    tpats.delete();
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [26:0] exp);
    if (idx < frames.size()) begin
      expect_eq({tag, "_bits"}, 32'(frames[idx]), 32'(exp));
      expect_eq({tag, "_dc_release"}, 32'(tpats[idx]), 32'(TPAT));
    end else begin
      expect_eq({tag, "_present"}, 32'(frames.size()), 32'(idx + 1));
    end
  endtask

  task automatic run_walk(input string tag, input int exp_cyc, input int pulse_at);
    int cyc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t0 = tcnt;
    expect_eq({tag, "_done_clr"}, 32'(done), 32'd0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 20000) begin
      cyc++;
      start = (cyc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    expect_eq({tag, "_busy_cyc"}, 32'(cyc), 32'(exp_cyc));
    expect_eq({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Bus monitor: decodes frames between START and STOP and flags stray SIOD edges under SIOC high.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else begin
        if (p_sioc && sioc && p_line && !line) begin
          if (in_frame) bad_frames++;
          in_frame = 1'b1;
          nbits = 0;
          t_start = tcnt;
          if (first_start < 0) first_start = tcnt;
        end else if (p_sioc && sioc && !p_line && line) begin
          if (in_frame && nbits == 28) begin
            frames.push_back(sr[27:1]);
            tpats.push_back(tsr[27:1]);
            last_span = tcnt - t_start;
          end else begin
            bad_frames++;
          end
          in_frame = 1'b0;
        end else if (!p_sioc && sioc && in_frame) begin
          sr  = {sr[26:0], line};
          tsr = {tsr[26:0], siod_t};
          nbits++;
        end
        if (!sioc && first_start < 0) early_low++;
      end
      p_sioc = sioc;
      p_line = line;
      tcnt++;
    end
  end

  // Saturation of the debug counter on a fast instance whose slave never acknowledges.
  initial begin
    int n;
    int timeouts;
    s_rst_n = 1'b0; s_start = 1'b0; sat_fin = 1'b0; timeouts = 0;
    repeat (3) @(negedge clk);
    s_rst_n = 1'b1;
    for (int w = 0; w < 23; w++) begin
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      n = 0;
      while (s_done !== 1'b1 && n < 2000) begin n++; @(negedge clk); end
      if (n >= 2000) timeouts++;
      if (w == 20) expect_eq("sat_nack_252", 32'(s_nack), 32'd252);
    end
    expect_eq("sat_walk_timeouts", 32'(timeouts), 32'd0);
    expect_eq("sat_nack_255", 32'(s_nack), 32'd255);
    sat_fin = 1'b1;
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; pull_high = 1'b0;
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    expect_eq("rst_sioc", 32'(sioc), 32'd1);
    expect_eq("rst_siod_t", 32'(siod_t), 32'd1);
    expect_eq("rst_siod_o", 32'(siod_o), 32'd0);
    expect_eq("rst_busy", 32'(busy), 32'd0);
    expect_eq("rst_done", 32'(done), 32'd0);
    expect_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    expect_eq("rst_nack", 32'(nack_cnt), 32'd0);
    rst_n = 1'b1;

    load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_walk("single", 1208, -1);
    expect_eq("single_frames", 32'(frames.size()), 32'd1);
    check_frame("single_f0", 0, frame(8'h42, 8'h12, 8'h80));
    expect_eq("single_start_to_stop", 32'(last_span), 32'd1130);
    expect_eq("single_idle_sioc", 32'(sioc), 32'd1);
    expect_eq("single_idle_siod_t", 32'(siod_t), 32'd1);

    load(16'hFFF0, 16'h1101, 16'hFFFF, 16'hFFFF);
    first_start = -1; early_low = 0;
    run_walk("delay", 1262, -1);
    expect_eq("delay_sioc_held", 32'(early_low), 32'd0);
    expect_eq("delay_ge_50", 32'(first_start - t0 >= 50), 32'd1);
    expect_eq("delay_frames", 32'(frames.size()), 32'd1);
    check_frame("delay_f0", 0, frame(8'h42, 8'h11, 8'h01));

    load(16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011);
    run_walk("full", 4817, -1);
    expect_eq("full_frames", 32'(frames.size()), 32'd4);
    check_frame("full_f0", 0, frame(8'h42, 8'h0A, 8'h0B));
    check_frame("full_f1", 1, frame(8'h42, 8'h0C, 8'h0D));
    check_frame("full_f2", 2, frame(8'h42, 8'h0E, 8'h0F));
    check_frame("full_f3", 3, frame(8'h42, 8'h10, 8'h11));
    expect_eq("full_no_wrap", 32'(rom_addr), 32'd3);

    load(16'h0A0B, 16'h0C0D, 16'hFFFF, 16'hFFFF);
    pull_high = 1'b1;
    run_walk("nack", 2412, -1);
    pull_high = 1'b0;
    expect_eq("nack_cnt_6", 32'(nack_cnt), 32'd6);

    load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_walk("ignore", 1208, 500);
    expect_eq("ignore_frames", 32'(frames.size()), 32'd1);
    load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_walk("restart", 1208, -1);
    check_frame("restart_f0", 0, frame(8'h42, 8'h12, 8'h80));

    load(16'h0A0B, 16'h0C0D, 16'hFFFF, 16'hFFFF);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(in_frame && nbits >= 13) && n < 3000) begin n++; @(negedge clk); end
    expect_eq("rst_mid_reached", 32'(in_frame), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    expect_eq("rst_mid_sioc", 32'(sioc), 32'd1);
    expect_eq("rst_mid_siod_t", 32'(siod_t), 32'd1);
    expect_eq("rst_mid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_walk("post_rst", 1208, -1);
    check_frame("post_rst_f0", 0, frame(8'h42, 8'h12, 8'h80));
    expect_eq("bad_frames", 32'(bad_frames), 32'd0);

    n = 0;
    while (sat_fin !== 1'b1 && n < 30000) begin n++; @(negedge clk); end
    expect_eq("sat_finished", 32'(sat_fin), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_sequencer.md
# sccb_cfg_sequencer

Boot-time camera configuration master. After `start`, it walks a register table of 16-bit `{reg_addr, reg_data}` entries held in an external synchronous ROM. For each entry it issues an SCCB 3-phase write on SIOC/SIOD, and it honours delay and end-of-table sentinels. It drives the same SIOD tristate triple (`siod_o`, `siod_t`, `siod_i`) that the top-level IOBUF expects, and replaces the AXI IIC path when camera bring-up must run without a processor.

## Interface
- `CLK_FREQ`, 100_000_000: system clock, Hz.
- `SCCB_FREQ`, 100_000: SIOC rate, Hz. `QTR = CLK_FREQ/(4*SCCB_FREQ)` must be ≥ 2.
- `SLAVE_ADDR`, 8'h42: 8-bit write ID sent in phase 1.
- `ROM_AW`, 8: ROM address width. Table depth is `2**ROM_AW`.
- `DELAY_CYCLES`, 1_000_000: wait length for a delay sentinel.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle request. Begins the table walk at entry 0.
- `busy` out 1: high from the cycle after an accepted `start` until `done` rises.
- `done` out 1: level. Set when the walk ends; cleared by the next accepted `start`.
- `rom_addr` out ROM_AW: table index.
- `rom_data` in 16: `{reg_addr[15:8], reg_data[7:0]}`. Valid 1 cycle after `rom_addr` changes.
- `sioc` out 1: SCCB clock, driven push-pull.
- `siod_o` out 1: SIOD output value.
- `siod_t` out 1: SIOD tristate enable, active-high. 1 = released.
- `siod_i` in 1: SIOD input. Sampled in the don't-care bit for the debug counter only.
- `nack_cnt` out 8: count of don't-care bits sampled high. Saturates at 255. Debug only.

## Operation
- Reset values: `sioc`=1, `siod_t`=1, `siod_o`=0, `busy`=0, `done`=0, `rom_addr`=0, `nack_cnt`=0. State returns to IDLE.
- Reset mid-transaction: the bus is released on the next edge. No stop condition is generated.
- States:
  - IDLE: `start` → FETCH, `rom_addr`←0.
  - FETCH: 2 cycles for ROM latency → DECODE.
  - DECODE:
    - 16'hFFFF → DONE.
    - 16'hFFF0 → DELAY.
    - Else → START.
  - START: 4 quarter periods.
  - BYTE: 3 phases × 9 bits × 4 quarters.
  - STOP: 4 quarter periods.
  - GAP: 4 quarter periods of bus-free time, then NEXT.
  - DELAY: `DELAY_CYCLES` cycles with bus idle → NEXT.
  - NEXT:
    - `rom_addr` = `2**ROM_AW-1` → DONE (the table end acts as a terminator; no wrap).
    - Else `rom_addr`+1 → FETCH.
  - DONE: `done`=1, `busy`=0 → IDLE on the same edge.
- `start` while `busy` is ignored. `start` while `done`=1 restarts from entry 0.
- Phase bytes: `SLAVE_ADDR`, `reg_addr`, `reg_data`. Each is sent MSB first and followed by one don't-care bit. During the don't-care bit the master releases SIOD (`siod_t`=1) and samples `siod_i` at the SIOC rising quarter.
- Driven data bit: `siod_t`=0, `siod_o`=bit. Idle and released: `siod_t`=1, `siod_o`=0.

## Timing
- Quarter tick every `QTR` clocks. The counter is cleared on every state entry.
- START:
  - q0: `sioc`=1, SIOD released.
  - q1: SIOD driven 0.
  - q2: hold.
  - q3: `sioc`=0.
- Bit:
  - q0: `sioc`=0, SIOD updated.
  - q1: `sioc`=1.
  - q2: `sioc`=1, sample point.
  - q3: `sioc`=0.
- STOP:
  - q0: `sioc`=0, SIOD driven 0.
  - q1: `sioc`=1.
  - q2: SIOD released.
  - q3: hold.
- One write = (4+108+4+4)·QTR = 120·QTR clocks, excluding FETCH/DECODE. At defaults this is 30_000 clocks.
- SIOD never changes while `sioc`=1, except the intended START and STOP edges.

## Structure
- Package `sccb_pkg`:
  - state enum;
  - `SENTINEL_END`=16'hFFFF;
  - `SENTINEL_DELAY`=16'hFFF0;
  - `BITS_PER_PHASE`=9;
  - `PHASES`=3.
- Sub-module `sccb_write_phy`:
  - Handshake: `go`/`ack`, plus `id`, `addr`, `data` inputs.
  - Owns the quarter counter, START/BYTE/STOP/GAP, the SIOC/SIOD outputs and `nack_cnt`.
  - The top holds the table walker (IDLE/FETCH/DECODE/DELAY/NEXT/DONE).

## Test plan
Bench parameters: CLK_FREQ=400, SCCB_FREQ=10 (QTR=10), DELAY_CYCLES=50, ROM_AW=2.
- Table {16'h1280, FFFF}, `start` → decoded SIOD bits 0x42, X, 0x12, X, 0x80, X. 1200 clocks from START entry to GAP end. `done`=1. Bus idle.
- Table {FFF0, 1101, FFFF} → `sioc` stays 1 for ≥50 cycles before the first START. One write of 0x11←0x01 follows.
- Table {0A0B, 0C0D, 0E0F, 1011} with no sentinel → 4 writes. `done` rises after entry 3. `rom_addr` does not wrap to 0.
- Pull `siod_i` high in every don't-care bit across 2 writes → `nack_cnt`=6. Preload 255 → stays 255.
- `rst_n` low mid-phase 2 → next edge `sioc`=1, `siod_t`=1, `busy`=0. A new `start` produces a clean START.
- `start` pulsed during `busy` → ignored, walk unchanged. `start` after `done` → `done` clears and entry 0 is re-sent.
- Checker throughout: SIOD is stable while `sioc`=1, except START/STOP edges.
